// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared constants, queue state encoding and address decode
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  function automatic logic [NUM_REGS-1:0] onehot_decode(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_port_if.sv
`default_nettype none
// ============================================================================
// regfile_write_port_if : writeback request handshake (valid/ready + addr/data)
// Revision              : 1.0
// ============================================================================
interface regfile_write_port_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/decoder_4to16.sv
`default_nettype none
// ============================================================================
// decoder_4to16 : gated address to one-hot register enable
// Revision      : 1.0
// ============================================================================
module decoder_4to16
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  assign onehot = en ? onehot_decode(addr) : '0;

endmodule
`default_nettype wire

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// regfile_write_port : 2-entry in-order write queue feeding the 16x16 bank
// Revision           : 1.0
// ============================================================================
module regfile_write_port #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DEPTH    = 2,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_write_port_if.slave        wr,
  input  logic                       hold,
  output logic [NUM_REGS-1:0]        wr_en_onehot,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        pending,
  output logic                       busy
);

  import regfile_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  q_state_t            r_state;
  logic                r_head;
  entry_t              r_entry [DEPTH];
  logic [DATA_W-1:0]   r_regs  [NUM_REGS];

  logic                w_push;
  logic                w_pop;
  logic                w_tail;
  entry_t              w_head_entry;
  logic [DEPTH-1:0]    w_slot_valid;
  logic [NUM_REGS-1:0] w_slot_onehot [DEPTH];
  logic [NUM_REGS-1:0] w_dec_commit;

  // Ready depends on state alone, so a pop never frees a slot in the same cycle.
  assign wr.wr_ready   = (r_state != Q_FULL);
  assign w_push        = wr.wr_valid & wr.wr_ready;
  assign w_pop         = ~hold & (r_state != Q_EMPTY);
  assign w_tail        = (r_state == Q_ONE) ? ~r_head : r_head;
  assign w_head_entry  = r_entry[r_head];
  assign busy          = (r_state != Q_EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= Q_EMPTY;
      r_head  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_entry[w_tail].addr <= wr.wr_addr;
        r_entry[w_tail].data <= wr.wr_data;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case (r_state)
        Q_EMPTY: begin
          if (w_push) r_state <= Q_ONE;
        end
        Q_ONE: begin
          if (w_push && !w_pop)      r_state <= Q_FULL;
          else if (!w_push && w_pop) r_state <= Q_EMPTY;
        end
        Q_FULL: begin
          if (w_pop) r_state <= Q_ONE;
        end
        default: r_state <= Q_EMPTY;
      endcase
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    assign w_slot_valid[s] = (r_state == Q_FULL) ||
                             ((r_state == Q_ONE) && (r_head == 1'(s)));
    decoder_4to16 u_dec_pending (
      .addr   (r_entry[s].addr),
      .en     (w_slot_valid[s]),
      .onehot (w_slot_onehot[s])
    );
  end

  always_comb begin
    pending = '0;
    for (int s = 0; s < DEPTH; s++) begin
      pending = pending | w_slot_onehot[s];
    end
  end

  decoder_4to16 u_dec_commit (
    .addr   (w_head_entry.addr),
    .en     (w_pop),
    .onehot (w_dec_commit)
  );

  // An r0 commit still pops the queue but never raises an enable.
  if (ZERO_R0) begin : g_r0_masked
    assign wr_en_onehot = {w_dec_commit[NUM_REGS-1:1], 1'b0};
  end else begin : g_r0_writable
    assign wr_en_onehot = w_dec_commit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_onehot[i]) r_regs[i] <= w_head_entry.data;
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_flat[r*DATA_W +: DATA_W] = r_regs[r];
  end

endmodule
`default_nettype wire
